uart_rx: RTL and testbench

UART receiver: the receive counterpart of the UART transmit path. It recovers DBIT-wide frames from the serial line `i_rx` using a 16x oversampling tick generated internally from the system clock. It presents each received word on `o_rx_data` with a one-cycle `o_rx_done` strobe, and flags a bad stop bit on `o_frame_error`. It sits beside the transmitter in the top level and can be looped back to `o_tx_2` for self-test.

---
 rtl/uart_rx.sv | 81 ++++++++
 tb/tb_uart_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver with internal baud tick and stop-bit frame-error flag.
module uart_rx #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_STATE = 2,
  parameter int DVSR     = 163,
  parameter int NB_DVSR  = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_rx_data,
  output logic            o_rx_done,
  output logic            o_frame_error
);
  localparam int NB_N = DBIT > 1 ? $clog2(DBIT) : 1;
  localparam logic [NB_DVSR-1:0] T_LAST = NB_DVSR'(DVSR - 1);
  localparam logic [NB_N-1:0]    N_LAST = NB_N'(DBIT - 1);
  localparam logic [3:0]         S_STOP = 4'(SB_TICK - 1);
  typedef enum logic [NB_STATE-1:0] {IDLE, START, DATA, STOP} state_t;
  logic               rx_m, rx_s, tick;
  logic [NB_DVSR-1:0] cnt;
  logic [3:0]         s;
  logic [NB_N-1:0]    n;
  logic [DBIT-1:0]    b;
  state_t             state;
  assign tick = cnt == T_LAST;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {i_rx, rx_m};
  // Free-running: the tick phase is independent of frame activity.
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state         <= IDLE;
      s             <= '0;
      n             <= '0;
      b             <= '0;
      o_rx_data     <= '0;
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            s     <= '0;
            state <= START;
          end
        START:
          if (tick) begin
            if (s == 4'd7) begin
              s     <= '0;
              n     <= '0;
              state <= rx_s ? IDLE : DATA;
            end else s <= s + 4'd1;
          end
        DATA:
          if (tick) begin
            if (s == 4'd15) begin
              s     <= '0;
              b     <= {rx_s, b[DBIT-1:1]};
              n     <= n == N_LAST ? n : n + 1'b1;
              state <= n == N_LAST ? STOP : DATA;
            end else s <= s + 4'd1;
          end
        STOP:
          if (tick) begin
            if (s == S_STOP) begin
              o_rx_data     <= b;
              o_frame_error <= ~rx_s;
              o_rx_done     <= 1'b1;
              state         <= IDLE;
            end else s <= s + 4'd1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frame checks plus glitch, break and mid-frame reset sequences.
module tb_uart_rx;
  localparam int DVSR = 4;
  localparam int BIT  = DVSR * 16;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;
  typedef struct {
    logic [7:0] d;
    logic       fe;
    int         t;
  } rec_t;
  logic       clk = 1'b0;
  logic       i_reset, i_rx;
  logic [7:0] o_rx_data;
  logic       o_rx_done, o_frame_error;
  int         cyc = 0;
  int         n_cmp = 0, n_bad = 0, n_consec = 0;
  logic       prev_done = 1'b0;
  rec_t       q[$];
  vec_t       vecs[9];
  uart_rx #(.DBIT(8), .SB_TICK(16), .NB_STATE(2), .DVSR(DVSR), .NB_DVSR(8)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_rx(i_rx),
    .o_rx_data(o_rx_data), .o_rx_done(o_rx_done), .o_frame_error(o_frame_error)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_rx_done) begin
      if (prev_done) n_consec++;
      q.push_back('{d: o_rx_data, fe: o_frame_error, t: cyc});
    end
    prev_done = o_rx_done;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // A bad stop bit is held low for 3/4 bit so the immediate re-start is rejected as a glitch.
  task automatic send(input logic [7:0] d, input logic stop, input int gap, output int t0);
    @(negedge clk);
    i_rx = 1'b0;
    t0 = cyc;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      idle(BIT);
    end
    if (stop) begin
      i_rx = 1'b1;
      idle(BIT);
    end else begin
      i_rx = 1'b0;
      idle(BIT * 3 / 4);
      i_rx = 1'b1;
      idle(BIT / 4);
    end
    idle(gap * BIT);
  endtask
  task automatic get_done(input string nm, output rec_t r, output bit ok);
    for (int i = 0; i < 4 * BIT && q.size() == 0; i++) @(negedge clk);
    ok = q.size() != 0;
    if (ok) r = q.pop_front();
    else chk({nm, "_timeout"}, 0, 1);
  endtask
  initial begin
    rec_t r;
    bit   ok;
    int   t0;
    vecs[0] = '{8'h55, 1'b1, 8, 8'h55, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 8, 8'h01, 1'b0};
    vecs[2] = '{8'h20, 1'b1, 8, 8'h20, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 2, 8'h3C, 1'b1};
    vecs[4] = '{8'h0F, 1'b1, 2, 8'h0F, 1'b0};
    vecs[5] = '{8'hA3, 1'b1, 0, 8'hA3, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 2, 8'hFF, 1'b0};
    vecs[7] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
    vecs[8] = '{8'h80, 1'b1, 1, 8'h80, 1'b0};
    i_reset = 1'b0;
    i_rx    = 1'b1;
    idle(50);
    chk("rst_data", o_rx_data, 0);
    chk("rst_done", o_rx_done, 0);
    chk("rst_fe", o_frame_error, 0);
    i_reset = 1'b1;
    idle(1300);
    chk("idle_no_done", q.size(), 0);
    // Start edge to done: 3 sync/detect clocks + tick phase (1..DVSR) + 151 ticks.
    foreach (vecs[k]) begin
      send(vecs[k].d, vecs[k].stop, vecs[k].gap, t0);
      get_done("frame", r, ok);
      if (ok) begin
        chk("frame_data", r.d, vecs[k].exp_d);
        chk("frame_fe", r.fe, vecs[k].exp_fe);
        chk_rng("frame_latency", r.t - t0, 151 * DVSR + 3, 152 * DVSR + 3 + DVSR);
      end
      chk("frame_extra_done", q.size(), 0);
    end
    @(negedge clk);
    i_rx = 1'b0;
    idle(12);
    i_rx = 1'b1;
    idle(800);
    chk("glitch_no_done", q.size(), 0);
    chk("glitch_data", o_rx_data, 8'h80);
    i_rx = 1'b0;
    idle(2000);
    i_rx = 1'b1;
    idle(1000);
    chk_rng("break_frames", q.size(), 3, 4);
    for (int i = 0; i < 2 && q.size() != 0; i++) begin
      r = q.pop_front();
      chk("break_data", r.d, 0);
      chk("break_fe", r.fe, 1);
    end
    q.delete();
    @(negedge clk);
    i_rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      i_rx = i[0];
      idle(BIT);
    end
    i_rx = 1'b0;
    idle(BIT / 2);
    i_reset = 1'b0;
    #1;
    chk("midrst_async_data", o_rx_data, 0);
    chk("midrst_async_fe", o_frame_error, 0);
    idle(50);
    chk("midrst_done", o_rx_done, 0);
    i_reset = 1'b1;
    i_rx = 1'b1;
    idle(800);
    chk("midrst_no_done", q.size(), 0);
    chk("midrst_data", o_rx_data, 0);
    send(8'h81, 1'b1, 2, t0);
    get_done("after_rst", r, ok);
    if (ok) begin
      chk("after_rst_data", r.d, 8'h81);
      chk("after_rst_fe", r.fe, 0);
    end
    chk("done_consecutive", n_consec, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
